// File: rtl/imem_loader_pkg.sv
// Shared CPU definitions for the writable instruction store and its byte-stream loader.
// Holds the loader state encoding, the fetch NOP and the default sizing constants.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } load_state_e;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
   localparam int          ADDR_W_DEF  = 8;
   localparam int          TIMEOUT_DEF = 50000;

   // A session length is usable when it is non-zero and fits in the store.
   function automatic logic len_ok(input logic [15:0] len, input int addr_w);
      return (len != 16'd0) && ({1'b0, len} <= (17'd1 << addr_w));
   endfunction

endpackage

// File: rtl/imem_loader_ram.sv
// Instruction word store: one synchronous write port, one combinational read port.
// Contents survive reset so a loaded program outlives a CPU reset.
module imem_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [31:0]       wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Writable instruction store with a byte-stream program loader.
// Stream: 16-bit word count (MSB first) then 4 bytes per instruction, MSB first.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | serving fetches, waiting for load_start
//   S_LEN_HI | taking word count high byte, CPU held
//   S_LEN_LO | taking word count low byte, length checked
//   S_DATA   | assembling bytes into words and writing the store
//   S_DONE   | single cycle completion pulse
//   S_ERR    | bad length or byte timeout; waits for a new load_start
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   input  logic [31:0]       cpu_pc,
   output logic [31:0]       cpu_instr,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int GAP_W = $clog2(TIMEOUT + 1);

   load_state_e       state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [ADDR_W-1:0] word_idx_q, word_idx_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [23:0]       shreg_q, shreg_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [ADDR_W:0]   words_q, words_d;

   logic              rx_ready_q, cpu_hold_q, load_done_q, load_err_q;
   logic              accept, gap_expired, ram_we;
   logic [15:0]       len_rx;
   logic [31:0]       ram_rdata;
   logic [31:0]       ram_wdata;
   logic [31-ADDR_W:0] unused_pc_bits;

   assign accept      = rx_valid & rx_ready_q;
   assign gap_expired = (gap_q == GAP_W'(TIMEOUT - 1));
   assign len_rx      = {len_q[15:8], rx_data};
   assign ram_we      = (state_q == S_DATA) && accept && (byte_cnt_q == 2'd3);
   assign ram_wdata   = {shreg_q, rx_data};

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_idx_d = word_idx_q;
      byte_cnt_d = byte_cnt_q;
      shreg_d    = shreg_q;
      gap_d      = gap_q;
      words_d    = words_q;

      case (state_q)
         S_IDLE, S_ERR: begin
            if (load_start) begin
               state_d = S_LEN_HI;
               gap_d   = '0;
            end
         end

         S_LEN_HI: begin
            if (accept) begin
               len_d[15:8] = rx_data;
               gap_d       = '0;
               state_d     = S_LEN_LO;
            end else if (gap_expired) begin
               state_d = S_ERR;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end

         S_LEN_LO: begin
            if (accept) begin
               len_d = len_rx;
               gap_d = '0;
               if (len_ok(len_rx, ADDR_W)) begin
                  state_d    = S_DATA;
                  word_idx_d = '0;
                  byte_cnt_d = '0;
                  words_d    = '0;
               end else begin
                  state_d = S_ERR;
               end
            end else if (gap_expired) begin
               state_d = S_ERR;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end

         S_DATA: begin
            if (accept) begin
               gap_d      = '0;
               shreg_d    = {shreg_q[15:0], rx_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               // The fourth byte completes a word; the store is written on this same edge.
               if (byte_cnt_q == 2'd3) begin
                  word_idx_d = word_idx_q + ADDR_W'(1);
                  words_d    = words_q + (ADDR_W+1)'(1);
                  if (16'(word_idx_q) == (len_q - 16'd1)) begin
                     state_d = S_DONE;
                  end
               end
            end else if (gap_expired) begin
               state_d = S_ERR;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         word_idx_q  <= '0;
         byte_cnt_q  <= '0;
         shreg_q     <= '0;
         gap_q       <= '0;
         words_q     <= '0;
         rx_ready_q  <= 1'b0;
         cpu_hold_q  <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         word_idx_q  <= word_idx_d;
         byte_cnt_q  <= byte_cnt_d;
         shreg_q     <= shreg_d;
         gap_q       <= gap_d;
         words_q     <= words_d;
         rx_ready_q  <= (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA);
         cpu_hold_q  <= (state_d != S_IDLE);
         load_done_q <= (state_d == S_DONE);
         load_err_q  <= (state_d == S_ERR);
      end
   end

   imem_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (word_idx_q),
      .wdata_i (ram_wdata),
      .raddr_i (cpu_pc[ADDR_W+1:2]),
      .rdata_o (ram_rdata)
   );

   // Upper PC bits and the byte offset play no part in the fetch.
   assign unused_pc_bits = {cpu_pc[31:ADDR_W+2], cpu_pc[1:0]};

   assign cpu_instr    = cpu_hold_q ? NOP_INSTR : ram_rdata;
   assign rx_ready     = rx_ready_q;
   assign cpu_hold     = cpu_hold_q;
   assign load_done    = load_done_q;
   assign load_err     = load_err_q;
   assign words_loaded = words_q;

endmodule
